// File: rtl/onchip_mem_stream_reader_if.sv
// Bus bundle for the memory stream reader: the Avalon-MM read port toward the
// on-chip RAM and the Avalon-ST source toward the streaming FIFO path.
interface onchip_mem_stream_reader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic [DATA_W-1:0]   src_data;
    logic                src_valid;
    logic                src_ready;
    logic                src_startofpacket;
    logic                src_endofpacket;

    modport master (
        output address, chipselect, write, byteenable,
        input  readdata,
        output src_data, src_valid, src_startofpacket, src_endofpacket,
        input  src_ready
    );

    modport slave (
        input  address, chipselect, write, byteenable,
        output readdata,
        input  src_data, src_valid, src_startofpacket, src_endofpacket,
        output src_ready
    );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that drains a contiguous word block from on-chip RAM
// and emits it as one Avalon-ST packet through a 2-entry output FIFO.
module onchip_mem_stream_reader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    onchip_mem_stream_reader_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  issue_left_q;
    logic [LEN_W-1:0]  out_left_q;
    logic [LEN_W-1:0]  len_q;
    logic              inflight_q;
    logic [1:0]        count_q;
    logic [DATA_W-1:0] buf0_q;
    logic [DATA_W-1:0] buf1_q;

    logic              pop;
    logic              issue;
    logic [2:0]        occ;

    // Issue a read only if the word it returns is guaranteed a free buffer slot.
    always_comb begin
        pop   = (count_q != 2'd0) && bus.src_ready;
        occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == S_RUN) && (issue_left_q != '0) && (occ < 3'd2);
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign bus.address           = addr_q;
    assign bus.chipselect        = issue;
    assign bus.write             = 1'b0;
    assign bus.byteenable        = '1;
    assign bus.src_data          = buf0_q;
    assign bus.src_valid         = (count_q != 2'd0);
    // The head word is always the next one the sink will take, so the
    // remaining-word counter identifies its position in the packet.
    assign bus.src_startofpacket = (count_q != 2'd0) && (out_left_q == len_q);
    assign bus.src_endofpacket   = (count_q != 2'd0) && (out_left_q == LEN_W'(1));

    // Command FSM, address/length counters and read-in-flight tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            len_q        <= '0;
            inflight_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                addr_q       <= addr_q + ADDR_W'(1);
                issue_left_q <= issue_left_q - LEN_W'(1);
            end
            if (pop) begin
                out_left_q <= out_left_q - LEN_W'(1);
            end
            if (abort) begin
                // Dropping the in-flight flag discards the word still on readdata.
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                inflight_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (length == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q      <= S_RUN;
                                busy_q       <= 1'b1;
                                addr_q       <= base_addr;
                                issue_left_q <= length;
                                out_left_q   <= length;
                                len_q        <= length;
                            end
                        end
                    end
                    S_RUN: begin
                        if (pop && (out_left_q == LEN_W'(1))) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // 2-entry output FIFO; head in buf0, a simultaneous pop and capture keeps age order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else if (abort) begin
            count_q <= 2'd0;
        end else begin
            case ({pop, inflight_q})
                2'b01: begin
                    if (count_q == 2'd0) begin
                        buf0_q <= bus.readdata;
                    end else begin
                        buf1_q <= bus.readdata;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b10: begin
                    buf0_q  <= buf1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        buf0_q <= buf1_q;
                        buf1_q <= bus.readdata;
                    end else begin
                        buf0_q <= bus.readdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader: stimulus queues the expected
// addresses and beats, a negedge monitor pops and compares them.
module tb_onchip_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] base_addr = '0;
    logic [14:0] length = '0;
    logic        busy;
    logic        done;

    onchip_mem_stream_reader_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    onchip_mem_stream_reader #(.ADDR_W(14), .DATA_W(32), .LEN_W(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_cs = 0;
    int n_beats = 0;
    int n_done = 0;
    int occ_max = 0;

    logic [33:0] exp_q[$];
    logic [13:0] exp_addr[$];
    logic        stalled = 1'b0;
    logic [34:0] held;

    // memory word at address a is a + 0xA0
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return {18'b0, a} + 32'h0000_00A0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory model: fixed 1-cycle read latency, junk when not selected.
    always @(posedge clk) begin
        bus.readdata <= bus.chipselect ? mem_word(bus.address) : 32'hDEAD_BEEF;
    end

    // Monitor: address order, beat contents, stall stability, occupancy.
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if ((n_cs - n_beats) > occ_max) occ_max = n_cs - n_beats;
            if (done) n_done++;
            if (bus.chipselect) begin
                n_cs++;
                if (exp_addr.size() == 0) chk("addr_extra", 64'(bus.address), 64'hFFFF);
                else chk("addr", 64'(bus.address), 64'(exp_addr.pop_front()));
            end
            if (stalled)
                chk("stall_hold", 64'({bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.src_data}), 64'(held));
            if (bus.src_valid && bus.src_ready) begin
                n_beats++;
                if (exp_q.size() == 0)
                    chk("beat_extra", 64'({bus.src_startofpacket, bus.src_endofpacket, bus.src_data}), 64'h3_FFFF_FFFF);
                else
                    chk("beat", 64'({bus.src_startofpacket, bus.src_endofpacket, bus.src_data}), 64'(exp_q.pop_front()));
            end
            stalled = bus.src_valid && !bus.src_ready && !abort;
            held = {bus.src_valid, bus.src_startofpacket, bus.src_endofpacket, bus.src_data};
        end
    end

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        return ((cyc % 5) == 0) || ((cyc % 5) == 3);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input int base, input int len, input int n_words);
        logic [13:0] a;
        for (int i = 0; i < len; i++) begin
            a = 14'((base + i) % 16384);
            exp_addr.push_back(a);
            if (i < n_words) exp_q.push_back({i == 0, i == len - 1, mem_word(a)});
        end
    endtask

    task automatic clear_counts();
        n_cs = 0; n_beats = 0; n_done = 0; occ_max = 0;
    endtask

    // Issue one command, stream it under the given ready pattern, check completion.
    task automatic run_cmd(input int base, input int len, input int mode, input int exp_cycles);
        int cyc;
        clear_counts();
        push_cmd(base, len, len);
        base_addr = 14'(base);
        length = 15'(len);
        start = 1'b1;
        bus.src_ready = rdy(mode, 0);
        cyc = 0;
        step();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            bus.src_ready = rdy(mode, cyc);
            step();
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        if (exp_cycles >= 0) chk("latency", 64'(cyc), 64'(exp_cycles));
        step();
        step();
        chk("done_pulse", 64'({done, n_done[7:0]}), 64'h001);
        chk("cs_count", 64'(n_cs), 64'(len));
        chk("beat_count", 64'(n_beats), 64'(len));
        chk("queue_empty", 64'(exp_q.size() + exp_addr.size()), 64'd0);
        chk("occupancy", 64'(occ_max <= 2), 64'd1);
    endtask

    initial begin
        bus.src_ready = 1'b1;
        #3;
        chk("reset_outs", 64'({busy, done, bus.chipselect, bus.write, bus.src_valid,
                                bus.src_startofpacket, bus.src_endofpacket}), 64'd0);
        chk("reset_addr_data", 64'({bus.address, bus.src_data}), 64'd0);
        chk("byteenable", 64'(bus.byteenable), 64'hF);
        step();
        reset = 1'b0;
        step();

        // basic 4-word packet, 0xB0..0xB3, no bubbles: last beat k+6, done k+7
        run_cmd(32'h0010, 4, 0, 7);
        // address wrap 0x3FFE,0x3FFF,0x0000,0x0001
        run_cmd(32'h3FFE, 4, 0, 7);
        // backpressure pattern 1,0,0,1,0...
        run_cmd(32'h0100, 8, 1, -1);
        // single word: SOP and EOP together
        run_cmd(32'h0123, 1, 0, 4);
        // zero length: done one cycle after start, nothing issued or streamed
        run_cmd(32'h0050, 0, 0, 1);

        // abort on the third beat while the sink stalls
        clear_counts();
        push_cmd(32'h0200, 10, 2);
        base_addr = 14'h0200; length = 15'd10; start = 1'b1; bus.src_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 50 && n_beats < 2; c++) step();
        chk("abort_reach", 64'(n_beats), 64'd2);
        bus.src_ready = 1'b0;
        abort = 1'b1;
        chk("third_beat", 64'({bus.src_valid, bus.src_data}), 64'h1_0000_02A2);
        step();
        abort = 1'b0;
        chk("abort_outs", 64'({bus.src_valid, busy, done, bus.chipselect}), 64'd0);
        exp_addr.delete();
        step(); step(); step();
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_quiet", 64'({bus.src_valid, bus.chipselect}), 64'd0);
        run_cmd(32'h0280, 2, 0, 5);

        // asynchronous reset mid-transfer
        clear_counts();
        push_cmd(32'h0300, 6, 6);
        base_addr = 14'h0300; length = 15'd6; start = 1'b1; bus.src_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_outs", 64'({busy, done, bus.chipselect, bus.src_valid,
                                   bus.src_startofpacket, bus.src_endofpacket}), 64'd0);
        chk("midreset_addr_data", 64'({bus.address, bus.src_data}), 64'd0);
        step();
        reset = 1'b0;
        exp_q.delete();
        exp_addr.delete();
        step();

        // new command; a second start while busy must be ignored
        clear_counts();
        push_cmd(32'h0400, 3, 3);
        base_addr = 14'h0400; length = 15'd3; start = 1'b1; bus.src_ready = 1'b0;
        step();
        start = 1'b0;
        step(); step();
        chk("busy_stalled", 64'(busy), 64'd1);
        base_addr = 14'h0500; length = 15'd5; start = 1'b1;
        step();
        start = 1'b0;
        bus.src_ready = 1'b1;
        for (int c = 0; c < 50 && !done; c++) step();
        chk("ignored_done", 64'(done), 64'd1);
        step(); step(); step();
        chk("ignored_beats", 64'(n_beats), 64'd3);
        chk("ignored_cs", 64'(n_cs), 64'd3);
        chk("ignored_done_cnt", 64'(n_done), 64'd1);
        chk("ignored_queues", 64'(exp_q.size() + exp_addr.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
